// File: rtl/adex_step_sequencer.sv
// adex_step_sequencer: sweeps NSLOT time-multiplexed neuron slots
// through one shared core per prescaler tick, with refractory skip.
module adex_step_sequencer #(
   parameter  int NSLOT = 4,
   parameter  int TMO   = 16,
   localparam int SW    = $clog2(NSLOT),
   localparam int TW    = $clog2(TMO + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [7:0]       period,
   input  logic [3:0]       refr_len,
   input  logic             cfg_req,
   output logic             cfg_gnt,
   output logic             core_start,
   output logic [SW-1:0]    core_sel,
   input  logic             core_done,
   input  logic             core_spike,
   input  logic [SW-1:0]    cnt_sel,
   input  logic             cnt_clr,
   output logic [7:0]       cnt_out,
   output logic [NSLOT-1:0] spike_vec,
   output logic             sweep_done,
   output logic             busy,
   output logic             overrun,
   output logic             timeout_err
);

   typedef enum logic [2:0] {IDLE, CFG, ISSUE, WAIT, NEXT} state_t;

   state_t           state, state_nx;
   logic [SW-1:0]    slot, slot_nx;
   logic [TW-1:0]    timer, timer_nx;
   logic [7:0]       presc;
   logic             pending;
   logic [NSLOT-1:0] acc;
   logic [7:0]       cnt  [NSLOT];
   logic [3:0]       refr [NSLOT];

   logic tick, accept, take_pend;
   logic rec, rec_bit, dec_refr, hit, tmo_hit;

   assign tick   = enable && (presc == period);
   // a tick is only banked when nothing is in flight and none is waiting
   assign accept = (state == IDLE || state == CFG) && !pending;

   assign busy     = (state != IDLE);
   assign core_sel = (state == ISSUE || state == WAIT || state == NEXT)
                     ? slot : '0;
   assign cnt_out  = cnt[cnt_sel];

   always_comb begin
      state_nx   = state;
      slot_nx    = slot;
      timer_nx   = timer;
      cfg_gnt    = 1'b0;
      core_start = 1'b0;
      sweep_done = 1'b0;
      take_pend  = 1'b0;
      rec        = 1'b0;
      rec_bit    = 1'b0;
      dec_refr   = 1'b0;
      hit        = 1'b0;
      tmo_hit    = 1'b0;
      unique case (state)
         IDLE: begin
            if (cfg_req) begin
               state_nx = CFG;
            end else if (enable && (tick || pending)) begin
               state_nx  = ISSUE;
               slot_nx   = '0;
               take_pend = 1'b1;
            end
         end
         CFG: begin
            cfg_gnt = 1'b1;
            if (!cfg_req) state_nx = IDLE;
         end
         ISSUE: begin
            if (refr[slot] != 4'd0) begin
               dec_refr = 1'b1;
               rec      = 1'b1;
               state_nx = NEXT;
            end else begin
               core_start = 1'b1;
               timer_nx   = '0;
               state_nx   = WAIT;
            end
         end
         WAIT: begin
            if (core_done) begin
               rec      = 1'b1;
               rec_bit  = core_spike;
               hit      = core_spike;
               state_nx = NEXT;
            end else if (timer == TW'(TMO - 1)) begin
               tmo_hit  = 1'b1;
               rec      = 1'b1;
               state_nx = NEXT;
            end else begin
               timer_nx = timer + TW'(1);
            end
         end
         NEXT: begin
            if (slot == SW'(NSLOT - 1)) begin
               sweep_done = 1'b1;
               slot_nx    = '0;
               state_nx   = IDLE;
            end else begin
               slot_nx  = slot + SW'(1);
               state_nx = ISSUE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         slot        <= '0;
         timer       <= '0;
         presc       <= '0;
         pending     <= 1'b0;
         acc         <= '0;
         spike_vec   <= '0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
         for (int i = 0; i < NSLOT; i++) begin
            cnt[i]  <= '0;
            refr[i] <= '0;
         end
      end else begin
         state <= state_nx;
         slot  <= slot_nx;
         timer <= timer_nx;
         if (!enable || tick) presc <= '0;
         else                 presc <= presc + 8'd1;
         if (!enable || take_pend)  pending <= 1'b0;
         else if (tick && accept)   pending <= 1'b1;
         if (tick && !accept) overrun <= 1'b1;
         if (tmo_hit)         timeout_err <= 1'b1;
         if (rec)             acc[slot] <= rec_bit;
         if (sweep_done)      spike_vec <= acc;
         // clear beats a same-cycle increment
         for (int i = 0; i < NSLOT; i++) begin
            if (cnt_clr)
               cnt[i] <= '0;
            else if (hit && SW'(i) == slot && cnt[i] != 8'hFF)
               cnt[i] <= cnt[i] + 8'd1;
         end
         if (hit)           refr[slot] <= refr_len;
         else if (dec_refr) refr[slot] <= refr[slot] - 4'd1;
      end
   end

endmodule

// File: tb/tb_adex_step_sequencer.sv
// tb_adex_step_sequencer: randomized core responder plus a per-sweep
// reference model of stepping, refractory, counting and timeouts.
module tb_adex_step_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [7:0] period = 8'd0;
   logic [3:0] refr_len = 4'd0;
   logic       cfg_req = 1'b0;
   logic       cfg_gnt, core_start;
   logic [1:0] core_sel;
   logic       core_done = 1'b0;
   logic       core_spike = 1'b0;
   logic [1:0] cnt_sel = 2'd0;
   logic       cnt_clr = 1'b0;
   logic [7:0] cnt_out;
   logic [3:0] spike_vec;
   logic       sweep_done, busy, overrun, timeout_err;

   adex_step_sequencer #(.NSLOT(4), .TMO(16)) dut (
      .clk(clk), .reset(reset), .enable(enable), .period(period),
      .refr_len(refr_len), .cfg_req(cfg_req), .cfg_gnt(cfg_gnt),
      .core_start(core_start), .core_sel(core_sel),
      .core_done(core_done), .core_spike(core_spike),
      .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_out(cnt_out),
      .spike_vec(spike_vec), .sweep_done(sweep_done), .busy(busy),
      .overrun(overrun), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int sel; int dly; int spk;} step_t;
   step_t q[$];

   // dly_tab: 0 never answers, 1..3 fixed, 4 random 1..3
   // spk_mode: 0 never, 1 always, 2 random
   int dly_tab[4];
   int spk_mode[4];
   int rsp_cnt = 0;
   int rsp_spk = 0;
   bit junk = 1'b0;

   int n_chk = 0;
   int n_pass = 0;
   int cnt_m[4];
   int refr_m[4];
   int to_m;

   int st[$];
   int sd, ov0, c1, c2, te0, bad, ns, sel;
   bit f;
   int tab[7] = '{4, 0, 0, 4, 0, 0, 4};

   always @(negedge clk) begin
      int d, sp;
      core_done  = 1'b0;
      core_spike = 1'b0;
      if (reset) begin
         rsp_cnt = 0;
      end else begin
         if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
               core_done  = 1'b1;
               core_spike = (rsp_spk != 0);
            end
         end else if (junk && !busy && $urandom_range(0, 7) == 0) begin
            core_done  = 1'b1;
            core_spike = 1'b1;
         end
         if (core_start) begin
            d = (dly_tab[core_sel] == 4) ? int'($urandom_range(1, 3))
                                         : dly_tab[core_sel];
            sp = (spk_mode[core_sel] == 2) ? int'($urandom_range(0, 1))
                                           : spk_mode[core_sel];
            rsp_cnt = d;
            rsp_spk = sp;
            q.push_back('{int'(core_sel), d, sp});
         end
      end
   end

   task automatic chk(input string tag, input int got, input int want);
      n_chk++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, want);
   endtask

   function automatic int outs();
      int r;
      r = {12'd0, core_start, cfg_gnt, core_sel, busy, sweep_done,
           spike_vec, overrun, timeout_err, cnt_out};
      return r;
   endfunction

   task automatic do_reset();
      reset   = 1'b1;
      enable  = 1'b0;
      cfg_req = 1'b0;
      cnt_clr = 1'b0;
      junk    = 1'b0;
      cnt_sel = 2'd0;
      repeat (2) @(negedge clk);
      chk("rst_outs", outs(), 0);
      reset = 1'b0;
      q.delete();
      for (int s = 0; s < 4; s++) begin
         cnt_m[s]  = 0;
         refr_m[s] = 0;
      end
      to_m = 0;
   endtask

   task automatic wait_sweep(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         seen = sweep_done;
      end
      chk("sweep_seen", int'(seen), 1);
   endtask

   task automatic model_sweep();
      int v, n_exp;
      step_t e;
      v = 0;
      n_exp = 0;
      for (int s = 0; s < 4; s++) if (refr_m[s] == 0) n_exp++;
      chk("steps", q.size(), n_exp);
      for (int s = 0; s < 4; s++) begin
         if (refr_m[s] > 0) begin
            refr_m[s]--;
         end else if (q.size() > 0) begin
            e = q.pop_front();
            chk("step_sel", e.sel, s);
            if (e.dly == 0) begin
               to_m = 1;
            end else if (e.spk != 0) begin
               v |= (1 << s);
               if (cnt_m[s] < 255) cnt_m[s]++;
               refr_m[s] = int'(refr_len);
            end
         end
      end
      q.delete();
      @(negedge clk);
      chk("spike_vec", int'(spike_vec), v);
      chk("timeout_err", int'(timeout_err), to_m);
      for (int s = 0; s < 4; s++) begin
         cnt_sel = 2'(s);
         #1;
         chk($sformatf("cnt%0d", s), int'(cnt_out), cnt_m[s]);
      end
   endtask

   task automatic set_rsp(input int d, input int s0, input int s1,
                          input int s2, input int s3);
      for (int s = 0; s < 4; s++) dly_tab[s] = d;
      spk_mode[0] = s0;
      spk_mode[1] = s1;
      spk_mode[2] = s2;
      spk_mode[3] = s3;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      set_rsp(1, 0, 0, 0, 0);
      do_reset();

      // sweep latency and overrun from back-to-back ticks
      set_rsp(1, 1, 0, 0, 0);
      period = 8'd3;
      enable = 1'b1;
      sd = -1;
      ov0 = -1;
      st.delete();
      for (int i = 0; i < 60 && sd < 0; i++) begin
         @(negedge clk);
         if (core_start) begin
            if (st.size() == 0) ov0 = int'(overrun);
            st.push_back(cyc);
         end
         if (sweep_done) sd = cyc;
      end
      chk("lat_n", st.size(), 4);
      if (st.size() == 4) begin
         chk("lat_s1", st[1] - st[0], 3);
         chk("lat_s2", st[2] - st[0], 6);
         chk("lat_s3", st[3] - st[0], 9);
         chk("lat_done", sd - st[0], 11);
      end
      chk("vec_pre", int'(spike_vec), 0);
      chk("ov_first", ov0, 0);
      @(negedge clk);
      chk("vec_post", int'(spike_vec), 1);
      chk("ov_set", int'(overrun), 1);
      enable = 1'b0;
      repeat (20) @(negedge clk);

      // slot 1 never answers
      do_reset();
      set_rsp(1, 1, 1, 1, 1);
      dly_tab[1] = 0;
      period = 8'd200;
      enable = 1'b1;
      c1 = -1;
      c2 = -1;
      te0 = -1;
      f = 1'b0;
      for (int i = 0; i < 400 && !f; i++) begin
         @(negedge clk);
         if (core_start && core_sel == 2'd1) begin
            c1 = cyc;
            te0 = int'(timeout_err);
         end
         if (core_start && core_sel == 2'd2) c2 = cyc;
         f = sweep_done;
      end
      chk("tmo_gap", c2 - c1, 18);
      chk("tmo_pre", te0, 0);
      chk("tmo_err", int'(timeout_err), 1);
      @(negedge clk);
      chk("tmo_vec", int'(spike_vec), 13);

      // config window raised together with a tick
      do_reset();
      set_rsp(1, 0, 0, 0, 0);
      period = 8'd0;
      enable = 1'b1;
      cfg_req = 1'b1;
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (!cfg_gnt || core_start) bad++;
      end
      chk("cfg_hold", bad, 0);
      cfg_req = 1'b0;
      @(negedge clk);
      chk("cfg_rel", int'(cfg_gnt), 0);
      chk("cfg_nostart", int'(core_start), 0);
      @(negedge clk);
      chk("cfg_start", int'(core_start), 1);
      chk("cfg_sel", int'(core_sel), 0);
      enable = 1'b0;
      wait_sweep(40);
      ns = 0;
      repeat (30) begin
         @(negedge clk);
         if (core_start) ns++;
      end
      chk("no_resweep", ns, 0);

      // reset while waiting on slot 2
      do_reset();
      set_rsp(1, 0, 0, 0, 0);
      dly_tab[2] = 0;
      period = 8'd15;
      enable = 1'b1;
      f = 1'b0;
      for (int i = 0; i < 100 && !f; i++) begin
         @(negedge clk);
         f = core_start && core_sel == 2'd2;
      end
      chk("r24_found", int'(f), 1);
      @(negedge clk);
      chk("r24_busy", int'(busy), 1);
      reset = 1'b1;
      @(negedge clk);
      chk("r24_outs", outs(), 0);
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      dly_tab[2] = 1;
      f = 1'b0;
      sel = -1;
      for (int i = 0; i < 60 && !f; i++) begin
         @(negedge clk);
         if (core_start) begin
            f = 1'b1;
            sel = int'(core_sel);
         end
      end
      chk("r24_restart", sel, 0);

      // refractory skipping on slot 2
      do_reset();
      set_rsp(1, 0, 0, 1, 0);
      refr_len = 4'd2;
      period = 8'd15;
      enable = 1'b1;
      for (int i = 0; i < 7; i++) begin
         wait_sweep(40);
         model_sweep();
         chk($sformatf("r20_vec%0d", i), int'(spike_vec), tab[i]);
      end
      cnt_sel = 2'd2;
      #1;
      chk("r20_cnt2", int'(cnt_out), 3);

      // counter saturation and clear-vs-increment
      do_reset();
      set_rsp(1, 1, 0, 0, 0);
      refr_len = 4'd0;
      period = 8'd12;
      enable = 1'b1;
      for (int i = 0; i < 260; i++) begin
         wait_sweep(40);
         model_sweep();
      end
      cnt_sel = 2'd0;
      #1;
      chk("sat255", int'(cnt_out), 255);
      chk("no_ovr", int'(overrun), 0);
      f = 1'b0;
      for (int i = 0; i < 40 && !f; i++) begin
         @(negedge clk);
         f = core_start && core_sel == 2'd0;
      end
      @(negedge clk);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      cnt_sel = 2'd0;
      #1;
      chk("clr_win", int'(cnt_out), 0);
      wait_sweep(40);
      q.delete();
      for (int s = 0; s < 4; s++) cnt_m[s] = 0;
      wait_sweep(40);
      model_sweep();

      // randomized responses, timeouts, refractory lengths, stray done
      do_reset();
      period = 8'($urandom_range(100, 200));
      refr_len = 4'($urandom_range(0, 3));
      set_rsp(4, 2, 2, 2, 2);
      junk = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 40; i++) begin
         wait_sweep(400);
         model_sweep();
         for (int s = 0; s < 4; s++)
            dly_tab[s] = ($urandom_range(0, 9) == 0) ? 0 : 4;
         refr_len = 4'($urandom_range(0, 3));
      end
      chk("rnd_ovr", int'(overrun), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
